// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; misses and all stores stall until main memory responds.
module dcache_wt #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    input  logic                  addr_mode,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    // state | meaning
    // IDLE  | accept CPU access; read hits served combinationally
    // FILL  | read miss outstanding on the memory port
    // WRITE | write-through store outstanding on the memory port

    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_WIDTH - IDX - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                state;
    logic [SETS-1:0]       validArr;
    logic [TAG-1:0]        tagArr  [SETS];
    logic [DATA_WIDTH-1:0] dataArr [SETS];

    logic [IDX-1:0]        cpuIdx;
    logic [TAG-1:0]        cpuTag;
    logic [IDX-1:0]        memIdx;
    logic [TAG-1:0]        memTag;
    logic                  cpuHit;
    logic                  memHit;
    logic [DATA_WIDTH-1:0] rdWord;
    logic [7:0]            rdByte;

    assign cpuIdx = addr[IDX+1:2];
    assign cpuTag = addr[ADDR_WIDTH-1:IDX+2];
    assign memIdx = mem_addr[IDX+1:2];
    assign memTag = mem_addr[ADDR_WIDTH-1:IDX+2];
    assign cpuHit = validArr[cpuIdx] && (tagArr[cpuIdx] == cpuTag);
    assign memHit = validArr[memIdx] && (tagArr[memIdx] == memTag);

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = we | (re & ~cpuHit);
                FILL:    stall = ~mem_ready;
                WRITE:   stall = ~mem_ready;
                default: stall = 1'b0;
            endcase
        end
    end

    // During a fill the word arrives on the memory port in the same cycle it is needed.
    always_comb begin
        rdWord = (state == FILL) ? mem_rdata : dataArr[cpuIdx];
        rdByte = rdWord[8*addr[1:0] +: 8];
        rdata  = '0;
        if (!rst) begin
            rdata = addr_mode ? {{(DATA_WIDTH-8){1'b0}}, rdByte} : rdWord;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            validArr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        state    <= WRITE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        if (addr_mode) begin
                            mem_wdata <= {4{wdata[7:0]}};
                            mem_be    <= 4'b0001 << addr[1:0];
                        end else begin
                            mem_wdata <= wdata;
                            mem_be    <= 4'b1111;
                        end
                    end else if (re && !cpuHit) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        validArr[memIdx] <= 1'b1;
                        mem_req          <= 1'b0;
                        state            <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Arrays carry no reset; reset forces IDLE, so an abandoned transaction never writes them.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ready) begin
            tagArr[memIdx]  <= memTag;
            dataArr[memIdx] <= mem_rdata;
        end
        if (state == WRITE && mem_ready && memHit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    dataArr[memIdx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
